// File: rtl/opc5ls_mem_arbiter.sv
// Round-robin arbiter sharing one 16-bit synchronous memory port between
// NREQ bus masters. A winner is granted and its address, data and direction
// are latched. The memory is strobed for WAIT_STATES+1 cycles, then a
// one-cycle ack returns the read data. A waiting master can be granted at
// the ack edge, so back-to-back accesses have no idle cycle between them.
module opc5ls_mem_arbiter #(
    parameter int NREQ        = 2,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rnw,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [15:0]          rdata,
    output logic                 mem_en,
    output logic                 mem_rnw,
    output logic [15:0]          mem_addr,
    output logic [15:0]          mem_dout,
    input  logic [15:0]          mem_din
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] last_ptr;   // most recently served master
    logic [IDX_W-1:0] owner;      // master currently holding the port

    logic [IDX_W-1:0] scan_base;
    logic [NREQ-1:0]  eligible;
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    int               cand;

    logic [NREQ-1:0]  sel_gnt;
    logic             sel_rnw;
    logic [15:0]      sel_addr;
    logic [15:0]      sel_wdata;

    // Round-robin pick: first asserted request after scan_base, wrapping.
    // In the ack cycle the finishing master is excluded and becomes the base.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        scan_base = last_ptr;
        eligible  = req;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        if (state == ST_ACK) begin
            scan_base       = owner;
            eligible[owner] = 1'b0;
        end
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(scan_base) + k) % NREQ;
            if (!arb_found && eligible[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Select the winner's bus fields and build its one-hot grant.
    always_comb begin
        sel_gnt          = '0;
        sel_gnt[arb_idx] = 1'b1;
        sel_rnw          = req_rnw[arb_idx];
        sel_addr         = req_addr[16*int'(arb_idx) +: 16];
        sel_wdata        = req_wdata[16*int'(arb_idx) +: 16];
    end

    // Access sequencer: grant, hold the memory strobe, capture data, ack.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked
        // block; an access in flight is dropped without an ack.
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            last_ptr <= IDX_W'(NREQ - 1);
            owner    <= '0;
            gnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            mem_en   <= 1'b0;
            mem_rnw  <= 1'b1;
            mem_addr <= '0;
            mem_dout <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register see the
            // pre-edge values of the others, independent of statement order.
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        owner    <= arb_idx;
                        gnt      <= sel_gnt;
                        mem_en   <= 1'b1;
                        mem_rnw  <= sel_rnw;
                        mem_addr <= sel_addr;
                        mem_dout <= sel_wdata;
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (mem_rnw) begin
                            rdata <= mem_din;
                        end
                        mem_en <= 1'b0;
                        ack    <= gnt;
                        state  <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    last_ptr <= owner;
                    if (arb_found) begin
                        owner    <= arb_idx;
                        gnt      <= sel_gnt;
                        mem_en   <= 1'b1;
                        mem_rnw  <= sel_rnw;
                        mem_addr <= sel_addr;
                        mem_dout <= sel_wdata;
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_ACCESS;
                    end else begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    gnt    <= '0;
                    mem_en <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opc5ls_mem_arbiter.sv
// Testbench for opc5ls_mem_arbiter: directed scenarios on a 4-master,
// one-wait-state instance and a 2-master, zero-wait-state instance, then
// randomized traffic on the 4-master instance against a reference model.
module tb_opc5ls_mem_arbiter;

    localparam int NA = 4;
    localparam int WA = 1;
    localparam int LA = WA + 2;   // cycles a master owns the port per access
    localparam int NB = 2;
    localparam int WB = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-master instance
    logic [NA-1:0]    req_a, rnw_a, gnt_a, ack_a;
    logic [16*NA-1:0] addr_a, wdata_a;
    logic [15:0]      rdata_a, mem_addr_a, mem_dout_a, mem_din_a;
    logic             mem_en_a, mem_rnw_a;

    // 2-master instance
    logic [NB-1:0]    req_b, rnw_b, gnt_b, ack_b;
    logic [16*NB-1:0] addr_b, wdata_b;
    logic [15:0]      rdata_b, mem_addr_b, mem_dout_b, mem_din_b;
    logic             mem_en_b, mem_rnw_b;

    int errors = 0;
    int checks = 0;

    opc5ls_mem_arbiter #(.NREQ(NA), .WAIT_STATES(WA)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .req_rnw(rnw_a),
        .req_addr(addr_a), .req_wdata(wdata_a), .gnt(gnt_a), .ack(ack_a),
        .rdata(rdata_a), .mem_en(mem_en_a), .mem_rnw(mem_rnw_a),
        .mem_addr(mem_addr_a), .mem_dout(mem_dout_a), .mem_din(mem_din_a)
    );

    opc5ls_mem_arbiter #(.NREQ(NB), .WAIT_STATES(WB)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .req_rnw(rnw_b),
        .req_addr(addr_b), .req_wdata(wdata_b), .gnt(gnt_b), .ack(ack_b),
        .rdata(rdata_b), .mem_en(mem_en_b), .mem_rnw(mem_rnw_b),
        .mem_addr(mem_addr_b), .mem_dout(mem_dout_b), .mem_din(mem_din_b)
    );

    function automatic logic [15:0] init_word(int i);
        return 16'(i * 37 + 261);
    endfunction

    // Memory behind instance a: 256 words, reloaded during reset; address
    // 0x1234 returns a fixed pattern.
    logic [15:0] ram_a [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram_a[i] <= init_word(i);
        end else if (mem_en_a && !mem_rnw_a) begin
            ram_a[mem_addr_a[7:0]] <= mem_dout_a;
        end
    end
    assign mem_din_a = (mem_addr_a == 16'h1234) ? 16'hBEEF : ram_a[mem_addr_a[7:0]];
    assign mem_din_b = mem_addr_b ^ 16'h5555;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_a = '0; rnw_a = '1; addr_a = '0; wdata_a = '0;
        req_b = '0; rnw_b = '1; addr_b = '0; wdata_b = '0;
        tick();
        tick();
        checks++;
        if ({gnt_a, ack_a, rdata_a, mem_en_a, mem_rnw_a, mem_addr_a, mem_dout_a} !==
            {4'b0, 4'b0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_a: got gnt=%b ack=%b rdata=%h en=%b rnw=%b addr=%h dout=%h, want all zero with rnw=1",
                     gnt_a, ack_a, rdata_a, mem_en_a, mem_rnw_a, mem_addr_a, mem_dout_a);
        end
        checks++;
        if ({gnt_b, ack_b, rdata_b, mem_en_b, mem_rnw_b, mem_addr_b, mem_dout_b} !==
            {2'b0, 2'b0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL reset_b: got gnt=%b ack=%b rdata=%h en=%b rnw=%b addr=%h dout=%h, want all zero with rnw=1",
                     gnt_b, ack_b, rdata_b, mem_en_b, mem_rnw_b, mem_addr_b, mem_dout_b);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        req_a[0] = 1'b1; rnw_a[0] = 1'b1;
        addr_a[15:0] = 16'h1234; wdata_a[15:0] = 16'h7777;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if ({gnt_a, ack_a, mem_en_a, mem_rnw_a, mem_addr_a} !==
                {4'b0001, 4'b0000, 1'b1, 1'b1, 16'h1234}) begin
                errors++;
                $display("FAIL read_access_c%0d: got gnt=%b ack=%b en=%b rnw=%b addr=%h, want 0001 0000 1 1 1234",
                         c, gnt_a, ack_a, mem_en_a, mem_rnw_a, mem_addr_a);
            end
            addr_a[15:0] = 16'hFFFF;  // owner inputs change; must be ignored
        end
        tick();
        checks++;
        if ({gnt_a, ack_a, mem_en_a, rdata_a} !== {4'b0001, 4'b0001, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL read_ack: got gnt=%b ack=%b en=%b rdata=%h, want 0001 0001 0 beef",
                     gnt_a, ack_a, mem_en_a, rdata_a);
        end
        req_a[0] = 1'b0;
        tick();
        checks++;
        if ({gnt_a, ack_a, mem_en_a} !== {4'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_idle: got gnt=%b ack=%b en=%b, want idle", gnt_a, ack_a, mem_en_a);
        end
    endtask

    task automatic test_write();
        req_a[1] = 1'b1; rnw_a[1] = 1'b0;
        addr_a[31:16] = 16'h0F00; wdata_a[31:16] = 16'h00A5;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if ({gnt_a, ack_a, mem_en_a, mem_rnw_a, mem_addr_a, mem_dout_a} !==
                {4'b0010, 4'b0000, 1'b1, 1'b0, 16'h0F00, 16'h00A5}) begin
                errors++;
                $display("FAIL write_access_c%0d: got gnt=%b ack=%b en=%b rnw=%b addr=%h dout=%h, want 0010 0000 1 0 0f00 00a5",
                         c, gnt_a, ack_a, mem_en_a, mem_rnw_a, mem_addr_a, mem_dout_a);
            end
            wdata_a[31:16] = 16'h1111;
        end
        tick();
        checks++;
        if ({gnt_a, ack_a, mem_en_a, rdata_a} !== {4'b0010, 4'b0010, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL write_ack: got gnt=%b ack=%b en=%b rdata=%h, want 0010 0010 0 beef",
                     gnt_a, ack_a, mem_en_a, rdata_a);
        end
        req_a[1] = 1'b0;
        tick();
        checks++;
        if ({gnt_a, ack_a, rdata_a} !== {4'b0, 4'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL write_after: got gnt=%b ack=%b rdata=%h, want 0000 0000 beef",
                     gnt_a, ack_a, rdata_a);
        end
    endtask

    // Both masters of the 2-master instance request continuously from reset.
    task automatic test_contention();
        logic [1:0] exp_gnt;
        int         owner;
        reset = 1'b1;
        req_b = 2'b11; rnw_b = 2'b11; addr_b = {16'h0B0B, 16'h0A0A};
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            owner   = (k / 2) % 2;
            exp_gnt = 2'(1 << owner);
            checks++;
            if ({gnt_b, ack_b, mem_en_b} !==
                {exp_gnt, (k % 2 == 1) ? exp_gnt : 2'b00, (k % 2 == 0)}) begin
                errors++;
                $display("FAIL contention_c%0d: got gnt=%b ack=%b en=%b, want gnt=%b ack=%b en=%b",
                         k, gnt_b, ack_b, mem_en_b, exp_gnt,
                         (k % 2 == 1) ? exp_gnt : 2'b00, (k % 2 == 0));
            end
            if (k % 2 == 1) begin
                checks++;
                if (rdata_b !== (addr_b[16*owner +: 16] ^ 16'h5555)) begin
                    errors++;
                    $display("FAIL contention_rdata_c%0d: got %h want %h",
                             k, rdata_b, addr_b[16*owner +: 16] ^ 16'h5555);
                end
            end
        end
        req_b = 2'b00;
        tick();
        checks++;
        if ({gnt_b, mem_en_b} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL contention_end: got gnt=%b en=%b want idle", gnt_b, mem_en_b);
        end
    endtask

    // Zero wait states: master 0 drops req one cycle after its grant.
    task automatic test_early_drop();
        int acks = 0;
        int grants = 0;
        req_b[0] = 1'b1; rnw_b[0] = 1'b1; addr_b[15:0] = 16'h0042;
        tick();
        checks++;
        if ({gnt_b, ack_b, mem_en_b, mem_addr_b} !== {2'b01, 2'b00, 1'b1, 16'h0042}) begin
            errors++;
            $display("FAIL drop_grant: got gnt=%b ack=%b en=%b addr=%h want 01 00 1 0042",
                     gnt_b, ack_b, mem_en_b, mem_addr_b);
        end
        req_b[0] = 1'b0;
        tick();
        checks++;
        if ({gnt_b, ack_b, mem_en_b, rdata_b} !== {2'b01, 2'b01, 1'b0, 16'h5517}) begin
            errors++;
            $display("FAIL drop_ack: got gnt=%b ack=%b en=%b rdata=%h want 01 01 0 5517",
                     gnt_b, ack_b, mem_en_b, rdata_b);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ack_b != 2'b00) acks++;
            if (gnt_b != 2'b00 || mem_en_b) grants++;
        end
        checks++;
        if (acks != 0 || grants != 0) begin
            errors++;
            $display("FAIL drop_no_regrant: got acks=%0d busy_cycles=%0d want 0 0", acks, grants);
        end
    endtask

    // Masters 0 and 2 hold req permanently; master 3 requests once.
    task automatic test_starvation();
        int  others = 0;
        logic g3 = 1'b0;
        logic a3 = 1'b0;
        req_a = 4'b0101; rnw_a = 4'b1111;
        tick();
        req_a[3] = 1'b1;
        for (int c = 0; c < 40 && !g3; c++) begin
            tick();
            if (gnt_a[3]) g3 = 1'b1;
            else if (ack_a != 4'b0) others++;
        end
        checks++;
        if (!g3 || others > NA - 1) begin
            errors++;
            $display("FAIL starve_bound: granted=%b after %0d other accesses, want granted within %0d",
                     g3, others, NA - 1);
        end
        checks++;
        if (others != 2) begin
            errors++;
            $display("FAIL starve_order: got %0d accesses before master3, want 2", others);
        end
        for (int c = 0; c < 10 && !a3; c++) begin
            tick();
            if (ack_a[3]) begin
                a3 = 1'b1;
                req_a[3] = 1'b0;
            end
        end
        checks++;
        if (!a3) begin
            errors++;
            $display("FAIL starve_ack: got no ack for master3 within 10 cycles, want one");
        end
        req_a = 4'b0;
        repeat (8) tick();
        checks++;
        if ({gnt_a, mem_en_a} !== {4'b0, 1'b0}) begin
            errors++;
            $display("FAIL starve_drain: got gnt=%b en=%b want idle", gnt_a, mem_en_a);
        end
    endtask

    task automatic test_abort_reset();
        req_a = 4'b0100; rnw_a = 4'b1111; addr_a[47:32] = 16'h0007;
        tick();
        checks++;
        if ({gnt_a, mem_en_a} !== {4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL abort_pre: got gnt=%b en=%b want 0100 1", gnt_a, mem_en_a);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({gnt_a, ack_a, rdata_a, mem_en_a, mem_rnw_a, mem_addr_a, mem_dout_a} !==
            {4'b0, 4'b0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL abort_state: got gnt=%b ack=%b rdata=%h en=%b rnw=%b addr=%h dout=%h, want reset state",
                     gnt_a, ack_a, rdata_a, mem_en_a, mem_rnw_a, mem_addr_a, mem_dout_a);
        end
        reset = 1'b0;
        req_a = 4'b0101;
        tick();
        checks++;
        if ({gnt_a, ack_a, mem_en_a} !== {4'b0001, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort_next_grant: got gnt=%b ack=%b en=%b want 0001 0000 1",
                     gnt_a, ack_a, mem_en_a);
        end
        req_a = 4'b0;
        repeat (6) tick();
    endtask

    // Random traffic against a transaction-level model: round-robin choice
    // from the request set seen at each arbitration point, fixed ownership
    // time, and a shadow memory updated by completed writes.
    task automatic test_random();
        int          m_owner, m_phase, m_ptr, excl, c;
        logic        found, m_rnw, exp_en;
        logic [3:0]  req_edge, exp_gnt, exp_ack;
        logic [15:0] m_addr, m_wdata, exp_rdata;
        logic [15:0] ref_mem [0:255];
        logic [15:0] rq_addr [NA];
        logic [15:0] rq_wdata [NA];
        logic        rq_rnw [NA];

        reset = 1'b1;
        req_a = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < NA; i++) begin
            rq_addr[i] = '0; rq_wdata[i] = '0; rq_rnw[i] = 1'b1;
        end
        m_owner = -1; m_phase = 0; m_ptr = NA - 1;
        m_rnw = 1'b1; m_addr = '0; m_wdata = '0; exp_rdata = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NA; i++) begin
                if (!req_a[i] && $urandom_range(0, 2) == 0) begin
                    rq_rnw[i]   = 1'($urandom);
                    rq_addr[i]  = 16'($urandom_range(0, 31));
                    rq_wdata[i] = 16'($urandom);
                    rnw_a[i]    = rq_rnw[i];
                    addr_a[16*i +: 16]  = rq_addr[i];
                    wdata_a[16*i +: 16] = rq_wdata[i];
                    req_a[i]    = 1'b1;
                end
            end
            req_edge = req_a;
            tick();

            if (m_owner >= 0 && m_phase < LA) begin
                m_phase++;
            end else begin
                excl = -1;
                if (m_owner >= 0) begin
                    m_ptr = m_owner;
                    excl  = m_owner;
                end
                m_owner = -1;
                found   = 1'b0;
                for (int k = 1; k <= NA; k++) begin
                    c = (m_ptr + k) % NA;
                    if (!found && req_edge[c] && c != excl) begin
                        found   = 1'b1;
                        m_owner = c;
                    end
                end
                if (found) begin
                    m_phase = 1;
                    m_rnw   = rq_rnw[m_owner];
                    m_addr  = rq_addr[m_owner];
                    m_wdata = rq_wdata[m_owner];
                end
            end

            exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
            exp_en  = (m_owner >= 0) && (m_phase < LA);
            exp_ack = (m_owner >= 0 && m_phase == LA) ? exp_gnt : 4'b0;
            if (m_owner >= 0 && m_phase == LA && m_rnw) exp_rdata = ref_mem[m_addr[7:0]];

            checks++;
            if ({gnt_a, ack_a, mem_en_a, rdata_a} !== {exp_gnt, exp_ack, exp_en, exp_rdata}) begin
                errors++;
                $display("FAIL random_c%0d: got gnt=%b ack=%b en=%b rdata=%h want gnt=%b ack=%b en=%b rdata=%h",
                         cyc, gnt_a, ack_a, mem_en_a, rdata_a, exp_gnt, exp_ack, exp_en, exp_rdata);
            end
            if (exp_en) begin
                checks++;
                if ({mem_rnw_a, mem_addr_a, mem_dout_a} !== {m_rnw, m_addr, m_wdata}) begin
                    errors++;
                    $display("FAIL random_bus_c%0d: got rnw=%b addr=%h dout=%h want rnw=%b addr=%h dout=%h",
                             cyc, mem_rnw_a, mem_addr_a, mem_dout_a, m_rnw, m_addr, m_wdata);
                end
            end
            if (m_owner >= 0 && m_phase == LA && !m_rnw) ref_mem[m_addr[7:0]] = m_wdata;

            for (int i = 0; i < NA; i++) begin
                if (ack_a[i]) req_a[i] = 1'b0;
            end
            if (exp_en) begin
                addr_a[16*m_owner +: 16]  = 16'($urandom);
                wdata_a[16*m_owner +: 16] = 16'($urandom);
                rnw_a[m_owner]            = 1'($urandom);
            end
        end
        req_a = '0;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_early_drop();
        test_starvation();
        test_abort_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/opc5ls_mem_arbiter.md
Name: opc5ls_mem_arbiter

Overview:
- Shares one 16-bit synchronous memory port between NREQ bus masters, e.g. two OPC5LS cores, or a core plus a DMA/video fetcher.
- Each master issues a req/ack transaction. The arbiter picks a winner round-robin, drives the memory for a fixed number of cycles, returns read data and pulses ack.
- The block sits between the masters' address/data/rnw buses and the shared RAM.

Parameters:
NREQ, 2, number of requesters (2..8).
WAIT_STATES, 1, extra memory cycles per access (0..15); mem_en is held for WAIT_STATES+1 cycles.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
req  input  NREQ  per-master request; held high until that master's ack.
req_rnw  input  NREQ  per-master direction: 1 = read, 0 = write.
req_addr  input  16*NREQ  per-master address; master i occupies bits [16i+15:16i].
req_wdata  input  16*NREQ  per-master write data, same packing.
gnt  output  NREQ  one-hot; identifies the current owner from grant cycle through ack cycle.
ack  output  NREQ  one-hot, single-cycle completion pulse.
rdata  output  16  read data, registered; valid on the ack cycle; held until the next read completes.
mem_en  output  1  memory access strobe.
mem_rnw  output  1  memory direction.
mem_addr  output  16  memory address.
mem_dout  output  16  memory write data.
mem_din  input  16  memory read data; valid on the last mem_en cycle.

Behaviour:
- Reset: gnt=0, ack=0, rdata=0, mem_en=0, mem_rnw=1, mem_addr=0, mem_dout=0, state=IDLE, wait counter=0, last-grant pointer=NREQ-1 so master 0 wins first. Reset asserted mid-access aborts the access with no ack; the next cycle matches the post-reset state.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - If no req: stay in IDLE.
  - Else pick the winner: the first asserted req scanning pointer+1, pointer+2, … modulo NREQ.
  - Register that master's addr, wdata and rnw into mem_addr, mem_dout and mem_rnw.
  - Set gnt[winner], mem_en=1, counter=WAIT_STATES, go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr, mem_dout and mem_rnw are held stable.
  - If counter≠0: decrement and stay.
  - If counter=0: capture mem_din into rdata when mem_rnw=1 (rdata unchanged on writes), drop mem_en, go to ACK.
- ACK:
  - ack[winner]=1 for exactly one cycle; gnt[winner] stays high; pointer=winner.
  - Arbitrate as in IDLE, excluding the winner (its req is still high this cycle).
  - If another req is pending: its grant is registered at the ACK clock edge, so the next cycle is ACCESS for the new master with gnt switched directly (no IDLE bubble) and the ack pulse ends.
  - Otherwise: gnt=0, go to IDLE.
- Latency: req sampled in IDLE → ack high WAIT_STATES+2 cycles later. Back-to-back service of different masters costs WAIT_STATES+2 cycles per access.
- Master drops req mid-access: the access still completes and ack is still pulsed (no abort).
- Master input changes while it owns the bus: ignored; all values were latched at grant.
- Fairness: a master with req continuously asserted waits at most NREQ-1 other accesses.
- Same master re-requests right after its ack: it is not considered in the ACK cycle; it is eligible in the next arbitration.
- gnt and ack are always zero or one-hot; ack is asserted only while the matching gnt bit is set.
- mem_en never asserts outside ACCESS.

Test Plan:
1. Reset, then a single read: WAIT_STATES=1; master0 reads 0x1234 and memory returns 0xBEEF. Required: mem_en high for 2 cycles with mem_addr=0x1234 and mem_rnw=1; ack[0] rises 3 cycles after the req sample; rdata=0xBEEF.
2. Write: master1 writes 0x00A5 to 0x0F00. Required: mem_rnw=0 and mem_dout=0x00A5 for the whole ACCESS; ack[1] pulses once; rdata keeps its previous value.
3. Contention: NREQ=2, both masters request continuously from reset. Required: grant order 0,1,0,1; no IDLE cycle between accesses; each ack is exactly 1 cycle.
4. Starvation check: NREQ=4, masters 0 and 2 hold req permanently and master 3 requests once. Required: master 3 is granted within 3 accesses.
5. Abort by reset: assert reset while in ACCESS. Required: the next cycle has mem_en=0, gnt=0, no ack, and the next grant goes to master 0.
6. Early req drop with WAIT_STATES=0: master0 deasserts req one cycle after grant. Required: the access completes, ack[0] pulses once, and master0 is not granted again.
